// File: rtl/cordic.sv
// Iterative rotation-mode CORDIC: sine/cosine of a signed 2.14 angle, one micro-rotation per clock.
// Results are registered and held until the next computation completes.
module cordic #(
  parameter int unsigned ITERATIONS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] angle,
  input  logic        start,
  output logic        done,
  output logic [15:0] sine,
  output logic [15:0] cosine,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRotate = 3'd2,
    StDone   = 3'd3
  } state_e;

  localparam logic signed [17:0] KGain  = 18'sd9949;
  localparam logic [3:0]         LastIt = 4'(ITERATIONS - 1);

  state_e            state_q, state_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]         i_q, i_d;
  logic [15:0]        ang_q, ang_d;
  logic [15:0]        sine_q, sine_d, cosine_q, cosine_d;
  logic signed [17:0] x_sh, y_sh, atan_i;

  function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
    unique case (idx)
      4'd0:    atan_lut = 18'sd12868;
      4'd1:    atan_lut = 18'sd7596;
      4'd2:    atan_lut = 18'sd4014;
      4'd3:    atan_lut = 18'sd2037;
      4'd4:    atan_lut = 18'sd1023;
      4'd5:    atan_lut = 18'sd512;
      4'd6:    atan_lut = 18'sd256;
      4'd7:    atan_lut = 18'sd128;
      4'd8:    atan_lut = 18'sd64;
      4'd9:    atan_lut = 18'sd32;
      4'd10:   atan_lut = 18'sd16;
      4'd11:   atan_lut = 18'sd8;
      4'd12:   atan_lut = 18'sd4;
      4'd13:   atan_lut = 18'sd2;
      4'd14:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    i_d      = i_q;
    ang_d    = ang_q;
    sine_d   = sine_q;
    cosine_d = cosine_q;
    x_sh     = x_q >>> i_q;
    y_sh     = y_q >>> i_q;
    atan_i   = atan_lut(i_q);

    case (state_q)
      StIdle: begin
        if (start) begin
          ang_d   = angle;
          state_d = StLoad;
        end
      end
      StLoad: begin
        x_d     = KGain;
        y_d     = '0;
        z_d     = {{2{ang_q[15]}}, ang_q};
        i_d     = '0;
        state_d = StRotate;
      end
      StRotate: begin
        // Rotate towards z = 0; both updates use the pre-rotation x and y.
        if (!z_q[17]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        i_d = i_q + 4'd1;
        if (i_q == LastIt) begin
          cosine_d = x_d[15:0];
          sine_d   = y_d[15:0];
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      i_q      <= '0;
      ang_q    <= '0;
      sine_q   <= '0;
      cosine_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      i_q      <= i_d;
      ang_q    <= ang_d;
      sine_q   <= sine_d;
      cosine_q <= cosine_d;
    end
  end

  assign done   = (state_q == StDone);
  assign sine   = sine_q;
  assign cosine = cosine_q;
  assign state  = state_q;

endmodule

// File: tb/tb_cordic.sv
// Scoreboard bench for cordic: expected sin/cos come from real-valued $sin/$cos,
// and a negedge monitor checks results, latency and hold behaviour whenever done is seen.
module tb_cordic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] angle = 16'd0;
  logic        done;
  logic [15:0] sine, cosine;
  logic [2:0]  state;

  cordic #(.ITERATIONS(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .angle  (angle),
    .start  (start),
    .done   (done),
    .sine   (sine),
    .cosine (cosine),
    .state  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e0;
    int s;
    int c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hold_chk = 1'b0;
  int   last_s = 0;
  int   last_c = 0;

  always @(posedge clk) cyc++;

  function automatic void model(input logic [15:0] a, output int s, output int c);
    real r;
    r = real'($signed(a)) / 16384.0;
    s = $rtoi($floor($sin(r) * 16384.0 + 0.5));
    c = $rtoi($floor($cos(r) * 16384.0 + 0.5));
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int diff;
    checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("done_drop", int'(done), 0, 0);
        chk("hold_sine", int'($signed(sine)), last_s, 8);
        chk("hold_cosine", int'($signed(cosine)), last_c, 8);
        hold_chk = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1, expected no pending result at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc - e.e0, 16, 0);
          chk("sine", int'($signed(sine)), e.s, 8);
          chk("cosine", int'($signed(cosine)), e.c, 8);
          last_s   = e.s;
          last_c   = e.c;
          hold_chk = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input int e0);
    exp_t e;
    e.e0 = e0;
    model(a, e.s, e.c);
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d pending results, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // One-cycle start pulse; angle is scrambled right after capture.
  task automatic issue(input logic [15:0] a);
    @(negedge clk);
    angle = a;
    start = 1'b1;
    push_exp(a, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    angle = 16'($urandom);
    wait_idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, int'(done), 0, 0);
    chk({tag, "_sine"}, int'(sine), 0, 0);
    chk({tag, "_cosine"}, int'(cosine), 0, 0);
    chk({tag, "_state"}, int'(state), 0, 0);
  endtask

  initial begin
    logic [15:0] dir[6];
    logic [15:0] a1, a2;
    int e0;
    dir = '{16'h0000, 16'h647B, 16'h4305, 16'h3244, 16'h2183, 16'hCDBC};

    // Reset held while start toggles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = k[0];
      angle = 16'($urandom);
      chk_reset_state("reset");
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_state", int'(state), 0, 0);
    end

    foreach (dir[k]) issue(dir[k]);

    for (int k = 0; k < 20; k++) issue(16'($urandom_range(0, 51472) - 25736));

    // start held high across DONE: second run begins on the first IDLE edge
    a1 = 16'($urandom_range(0, 51472) - 25736);
    a2 = 16'($urandom_range(0, 51472) - 25736);
    @(negedge clk);
    angle = a1;
    start = 1'b1;
    e0 = cyc + 1;
    push_exp(a1, e0);
    push_exp(a2, e0 + 18);
    @(negedge clk);
    angle = a2;
    while (cyc < e0 + 18) @(negedge clk);
    start = 1'b0;
    angle = 16'($urandom);
    wait_idle();

    // start toggled during ROTATE is ignored
    @(negedge clk);
    angle = 16'h3244;
    start = 1'b1;
    push_exp(16'h3244, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = ~start;
      angle = 16'($urandom);
    end
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset mid-ROTATE: immediate IDLE, outputs zeroed, no done
    @(negedge clk);
    angle = 16'h2183;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_reset_state", int'(state), 0, 0);
    chk("post_reset_sine", int'(sine), 0, 0);

    issue(16'hCDBC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
